// File: rtl/serial_shift_engine.sv
// Multi-lane shift/rotate engine: loads a word, then shifts it LANES bits per step
// for a programmed number of steps. A one-cycle done pulse marks completion.
module serial_shift_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 1,
  localparam int unsigned STEPS = WIDTH / LANES,
  localparam int unsigned CW = $clog2(STEPS + 1)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [WIDTH-1:0] resetValue,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [1:0]       load_mode,
  input  logic [CW-1:0]    load_count,
  input  logic             hold,
  input  logic [LANES-1:0] serial_in,
  output logic [LANES-1:0] serial_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    count_clamped;

  assign count_clamped = (load_count > CW'(STEPS)) ? CW'(STEPS) : load_count;

  always_comb begin
    shifted = data_q;
    case (mode_q)
      2'b00:   shifted = {data_q[WIDTH-LANES-1:0], serial_in};
      2'b01:   shifted = {serial_in, data_q[WIDTH-1:LANES]};
      2'b10:   shifted = {data_q[WIDTH-LANES-1:0], data_q[WIDTH-1:WIDTH-LANES]};
      default: shifted = {{LANES{data_q[WIDTH-1]}}, data_q[WIDTH-1:LANES]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          data_d  = load_data;
          mode_d  = load_mode;
          rem_d   = count_clamped;
          state_d = (count_clamped == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          data_d = shifted;
          rem_d  = rem_q - CW'(1);
          if (rem_q <= CW'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q <= IDLE;
      data_q  <= resetValue;
      rem_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  // Right-going modes expose the low lanes; left-going modes the high lanes.
  assign serial_out = mode_q[0] ? data_q[LANES-1:0] : data_q[WIDTH-1:WIDTH-LANES];
  assign data_out   = data_q;
  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT) || (state_q == DONE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_shift_engine.sv
// Directed bench for serial_shift_engine: a 1-lane and a 4-lane instance of a 16-bit engine.
module tb_serial_shift_engine;

  logic        clock = 1'b0;
  logic        resetN;
  logic [15:0] resetValue;
  logic [15:0] load_data;
  logic [1:0]  load_mode;
  logic        hold;

  logic        lv_a, lr_a, so_a, busy_a, done_a, si_a;
  logic [4:0]  cnt_a;
  logic [15:0] do_a;

  logic        lv_b, lr_b, busy_b, done_b;
  logic [3:0]  si_b, so_b;
  logic [2:0]  cnt_b;
  logic [15:0] do_b;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clock = ~clock;

  serial_shift_engine #(.WIDTH(16), .LANES(1)) dut_a (
    .clock(clock), .resetN(resetN), .resetValue(resetValue),
    .load_valid(lv_a), .load_ready(lr_a), .load_data(load_data),
    .load_mode(load_mode), .load_count(cnt_a), .hold(hold),
    .serial_in(si_a), .serial_out(so_a), .data_out(do_a),
    .busy(busy_a), .done(done_a)
  );

  serial_shift_engine #(.WIDTH(16), .LANES(4)) dut_b (
    .clock(clock), .resetN(resetN), .resetValue(resetValue),
    .load_valid(lv_b), .load_ready(lr_b), .load_data(load_data),
    .load_mode(load_mode), .load_count(cnt_b), .hold(hold),
    .serial_in(si_b), .serial_out(so_b), .data_out(do_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    resetN = 1'b0; resetValue = 16'hA5A5; load_data = '0; load_mode = 2'b00; hold = 1'b0;
    lv_a = 1'b0; cnt_a = '0; si_a = 1'b0;
    lv_b = 1'b0; cnt_b = '0; si_b = '0;

    // Reset state
    step();
    chk("rst_data_a", 32'(do_a), 32'hA5A5);
    chk("rst_data_b", 32'(do_b), 32'hA5A5);
    chk("rst_ready_a", 32'(lr_a), 32'h1);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_done_a", 32'(done_a), 32'h0);
    resetN = 1'b1;
    step();

    // Logical left, serial_in=1, 3 steps
    lv_a = 1'b1; load_data = 16'h8001; load_mode = 2'b00; cnt_a = 5'd3; si_a = 1'b1;
    step();
    lv_a = 1'b0;
    chk("ll_busy", 32'(busy_a), 32'h1);
    chk("ll_ready", 32'(lr_a), 32'h0);
    chk("ll_sout0", 32'(so_a), 32'h1);
    step();
    chk("ll_d1", 32'(do_a), 32'h0003);
    step();
    chk("ll_d2", 32'(do_a), 32'h0007);
    chk("ll_nodone2", 32'(done_a), 32'h0);
    step();
    chk("ll_done", 32'(done_a), 32'h1);
    chk("ll_final", 32'(do_a), 32'h000F);
    step();
    chk("ll_done_once", 32'(done_a), 32'h0);
    chk("ll_idle_ready", 32'(lr_a), 32'h1);

    // Back-to-back: arithmetic right, 4 steps
    lv_a = 1'b1; load_data = 16'h8000; load_mode = 2'b11; cnt_a = 5'd4; si_a = 1'b0;
    step();
    lv_a = 1'b0;
    chk("ar_sout0", 32'(so_a), 32'h0);
    step(); step(); step();
    chk("ar_d3", 32'(do_a), 32'hF000);
    chk("ar_nodone3", 32'(done_a), 32'h0);
    step();
    chk("ar_done", 32'(done_a), 32'h1);
    chk("ar_final", 32'(do_a), 32'hF800);
    step();

    // Count 0 goes straight to DONE
    lv_a = 1'b1; load_data = 16'h1111; load_mode = 2'b01; cnt_a = 5'd0;
    step();
    lv_a = 1'b0;
    chk("c0_done", 32'(done_a), 32'h1);
    chk("c0_data", 32'(do_a), 32'h1111);
    step();

    // 4-lane rotate left, count 1
    lv_b = 1'b1; load_data = 16'h1234; load_mode = 2'b10; cnt_b = 3'd1; si_b = 4'hF;
    step();
    lv_b = 1'b0;
    chk("rl1_sout0", 32'(so_b), 32'h1);
    step();
    chk("rl1_done", 32'(done_b), 32'h1);
    chk("rl1_data", 32'(do_b), 32'h2341);
    step();

    // 4-lane rotate left, count 7 clamps to 4
    lv_b = 1'b1; load_data = 16'h1234; load_mode = 2'b10; cnt_b = 3'd7;
    step();
    lv_b = 1'b0;
    step(); step(); step();
    chk("rl4_d3", 32'(do_b), 32'h4123);
    chk("rl4_nodone3", 32'(done_b), 32'h0);
    step();
    chk("rl4_done", 32'(done_b), 32'h1);
    chk("rl4_data", 32'(do_b), 32'h1234);
    step();
    chk("rl4_idle", 32'(lr_b), 32'h1);

    // Logical right with a 2-cycle hold and an ignored load while busy
    lv_a = 1'b1; load_data = 16'hF000; load_mode = 2'b01; cnt_a = 5'd4; si_a = 1'b0;
    step();
    lv_a = 1'b0;
    chk("lr_sout0", 32'(so_a), 32'h0);
    step(); step();
    chk("lr_d2", 32'(do_a), 32'h3C00);
    hold = 1'b1; lv_a = 1'b1; load_data = 16'hFFFF; cnt_a = 5'd1;
    step();
    chk("hold_d1", 32'(do_a), 32'h3C00);
    step();
    chk("hold_d2", 32'(do_a), 32'h3C00);
    chk("hold_busy", 32'(busy_a), 32'h1);
    hold = 1'b0; lv_a = 1'b0;
    step();
    chk("lr_d3", 32'(do_a), 32'h1E00);
    chk("lr_nodone3", 32'(done_a), 32'h0);
    step();
    chk("lr_done", 32'(done_a), 32'h1);
    chk("lr_final", 32'(do_a), 32'h0F00);
    hold = 1'b1;
    step();
    hold = 1'b0;
    chk("hold_ign_done", 32'(lr_a), 32'h1);
    chk("busy_load_ign", 32'(do_a), 32'h0F00);

    // Reset mid-SHIFT aborts without done
    resetValue = 16'h5A5A;
    lv_a = 1'b1; load_data = 16'h00FF; load_mode = 2'b00; cnt_a = 5'd10; si_a = 1'b0;
    step();
    lv_a = 1'b0;
    step();
    chk("ab_d1", 32'(do_a), 32'h01FE);
    resetN = 1'b0;
    step();
    chk("ab_data", 32'(do_a), 32'h5A5A);
    chk("ab_nodone", 32'(done_a), 32'h0);
    chk("ab_ready", 32'(lr_a), 32'h1);
    resetN = 1'b1;
    step();
    chk("ab_nodone2", 32'(done_a), 32'h0);
    chk("ab_hold_val", 32'(do_a), 32'h5A5A);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
